vga_line_buffer: RTL and testbench



---
 rtl/vga_lb_pkg.sv | 15 +
 rtl/lb_dpram.sv | 29 ++
 rtl/vga_line_buffer.sv | 134 +++++++++++++
 tb/tb_vga_line_buffer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_lb_pkg.sv
// Shared types and default constants for the VGA ping-pong line buffer.
package vga_lb_pkg;

    localparam int H_DATA_DEF = 640;
    localparam int DATA_W_DEF = 16;
    localparam logic [15:0] UNDERFLOW_COLOR_DEF = 16'hF81F;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_READING
    } bank_state_t;

endpackage

// File: rtl/lb_dpram.sv
// Two-bank simple dual-port line RAM, address {bank, column}, 1-cycle read.
module lb_dpram
    import vga_lb_pkg::*;
#(
    parameter int H_DATA = H_DATA_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int CW = $clog2(H_DATA)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [CW:0]       wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [CW:0]       rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2][H_DATA];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[CW]][wr_addr[CW-1:0]] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr[CW]][rd_addr[CW-1:0]];
        end
    end

endmodule

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer feeding the VGA timing controller.
// Define VGA_LB_UNDERFLOW_CNT_EN to add the saturating underflow_cnt port.
module vga_line_buffer
    import vga_lb_pkg::*;
#(
    parameter int                 H_DATA          = H_DATA_DEF,
    parameter int                 DATA_W          = DATA_W_DEF,
    parameter logic [DATA_W-1:0]  UNDERFLOW_COLOR = DATA_W'(UNDERFLOW_COLOR_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_sol,
    output logic              wr_ready,
    input  logic              data_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              underflow
`ifdef VGA_LB_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]       underflow_cnt
`endif
);

    localparam int CW = $clog2(H_DATA);
    localparam logic [CW-1:0] LAST = CW'(H_DATA - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    bank_state_t       bank_st [2];
    logic              wb;
    logic              rb;
    logic [CW-1:0]     wcol;
    logic [CW-1:0]     rcol;
    logic              uf_line;
    logic              rd_vld;
    logic              rd_uf;
    logic              uf_pulse;
    logic              wr_acc;
    logic              rd_go;
    logic              uf_start;
    logic [CW-1:0]     wr_col;
    logic [DATA_W-1:0] ram_q;

    assign wr_ready = (bank_st[wb] == BANK_EMPTY) ||
                      (bank_st[wb] == BANK_FILLING);
    assign wr_acc   = wr_valid && wr_ready && !frame_start;
    assign rd_go    = data_req && !frame_start;
    assign uf_start = rd_go && (rcol == '0) && (bank_st[rb] != BANK_FULL);
    assign wr_col   = wr_sol ? '0 : wcol;

    lb_dpram #(
        .H_DATA (H_DATA),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr ({wb, wr_col}),
        .wr_data (wr_data),
        .rd_en   (rd_go),
        .rd_addr ({rb, rcol}),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            wb         <= 1'b0;
            rb         <= 1'b0;
            wcol       <= '0;
            rcol       <= '0;
            uf_line    <= 1'b0;
            rd_vld     <= 1'b0;
            rd_uf      <= 1'b0;
            uf_pulse   <= 1'b0;
        end else if (frame_start) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            wb         <= 1'b0;
            rb         <= 1'b0;
            wcol       <= '0;
            rcol       <= '0;
            uf_line    <= 1'b0;
            rd_vld     <= 1'b0;
            rd_uf      <= 1'b0;
            uf_pulse   <= 1'b0;
        end else begin
            rd_vld   <= data_req;
            uf_pulse <= uf_start;
            if (wr_acc) begin
                if (wr_col == LAST) begin
                    bank_st[wb] <= BANK_FULL;
                    wcol        <= '0;
                    wb          <= ~wb;
                end else begin
                    bank_st[wb] <= BANK_FILLING;
                    wcol        <= wr_col + ONE;
                end
            end
            // Write and read never share a bank, so these updates are independent.
            if (data_req) begin
                rcol <= (rcol == LAST) ? '0 : rcol + ONE;
                if (rcol == '0) begin
                    uf_line <= uf_start;
                    rd_uf   <= uf_start;
                    if (!uf_start) begin
                        bank_st[rb] <= BANK_READING;
                    end
                end else begin
                    rd_uf <= uf_line;
                    if (rcol == LAST && !uf_line) begin
                        bank_st[rb] <= BANK_EMPTY;
                        rb          <= ~rb;
                    end
                end
            end
        end
    end

    assign rd_data   = rd_vld ? (rd_uf ? UNDERFLOW_COLOR : ram_q) : '0;
    assign underflow = uf_pulse;

`ifdef VGA_LB_UNDERFLOW_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_cnt <= '0;
        end else if (uf_start && underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_line_buffer.sv
// Self-checking bench for vga_line_buffer: queue-based line model plus
// directed scenarios with literal expectations.
module tb_vga_line_buffer;

    localparam int H = 640;
    localparam logic [15:0] UC = 16'hF81F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_sol;
    logic        wr_ready;
    logic        data_req;
    logic [15:0] rd_data;
    logic        underflow;
`ifdef VGA_LB_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    vga_line_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_sol        (wr_sol),
        .wr_ready      (wr_ready),
        .data_req      (data_req),
        .rd_data       (rd_data),
        .underflow     (underflow)
`ifdef VGA_LB_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: completed lines queued in order, plus the line being assembled.
    logic [15:0] m_fifo[$];
    logic [15:0] m_part[$];
    logic [15:0] m_cur[H];
    int          m_nfull;
    bit          m_reading;
    int          m_rpos;
    bit          m_ufl;
    bit          m_acc;
    logic [15:0] e_rd;
    bit          e_uf;
    int          e_ucnt;

    function automatic bit m_ready();
        return (m_nfull + int'(m_reading)) < 2;
    endfunction

    function automatic void m_clear();
        m_fifo.delete();
        m_part.delete();
        m_nfull   = 0;
        m_reading = 0;
        m_rpos    = 0;
        m_ufl     = 0;
        e_rd      = '0;
        e_uf      = 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear();
            e_ucnt = 0;
        end else begin
            m_acc = wr_valid && m_ready();
            e_rd  = '0;
            e_uf  = 0;
            if (frame_start) begin
                m_clear();
            end else begin
                if (data_req) begin
                    if (m_rpos == 0) begin
                        if (m_nfull > 0) begin
                            m_nfull--;
                            m_reading = 1;
                            m_ufl     = 0;
                            for (int k = 0; k < H; k++) m_cur[k] = m_fifo.pop_front();
                        end else begin
                            m_ufl = 1;
                            e_uf  = 1;
                            if (e_ucnt < 65535) e_ucnt++;
                        end
                    end
                    e_rd = m_ufl ? UC : m_cur[m_rpos];
                    m_rpos++;
                    if (m_rpos == H) begin
                        m_rpos = 0;
                        if (!m_ufl) m_reading = 0;
                    end
                end
                if (m_acc) begin
                    if (wr_sol) m_part.delete();
                    m_part.push_back(wr_data);
                    if (m_part.size() == H) begin
                        foreach (m_part[k]) m_fifo.push_back(m_part[k]);
                        m_part.delete();
                        m_nfull++;
                    end
                end
            end
        end
    end

    logic        req_q;
    logic [15:0] cap[$];
    int          uf_seen;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_q <= 1'b0;
        else        req_q <= data_req;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("rd_data", 32'(rd_data), 32'(e_rd));
            chk("underflow", 32'(underflow), 32'(e_uf));
            chk("wr_ready", 32'(wr_ready), 32'(m_ready()));
`ifdef VGA_LB_UNDERFLOW_CNT_EN
            chk("underflow_cnt", 32'(underflow_cnt), 32'(e_ucnt));
`endif
            if (req_q) cap.push_back(rd_data);
            if (underflow) uf_seen++;
        end
    end

    task automatic push_px(input logic [15:0] d, input bit sol);
        int t;
        t = 0;
        while (!wr_ready && t < 3000) begin
            wr_valid = 1'b0;
            @(negedge clk);
            t++;
        end
        if (!wr_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL wr_ready_wait: got 0 expected 1 at %0t", $time);
        end
        wr_valid = 1'b1;
        wr_data  = d;
        wr_sol   = sol;
        @(negedge clk);
    endtask

    task automatic write_end();
        wr_valid = 1'b0;
        wr_sol   = 1'b0;
        @(negedge clk);
    endtask

    task automatic req_burst(input int n);
        for (int i = 0; i < n; i++) begin
            data_req = 1'b1;
            @(negedge clk);
        end
        data_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic flush();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_cap();
        cap.delete();
        uf_seen = 0;
    endtask

    task automatic chk_all_uc(string nm);
        int bad;
        bad = 0;
        foreach (cap[k]) if (cap[k] !== UC) bad++;
        chk({nm, "_size"}, 32'(cap.size()), 32'(H));
        chk({nm, "_bad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        wr_valid    = 1'b0;
        wr_data     = '0;
        wr_sol      = 1'b0;
        data_req    = 1'b0;
        uf_seen     = 0;
        repeat (3) @(negedge clk);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
`ifdef VGA_LB_UNDERFLOW_CNT_EN
        chk("rst_ucnt", 32'(underflow_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Single line, value = column
        for (int i = 0; i < H; i++) push_px(16'(i), i == 0);
        write_end();
        clear_cap();
        req_burst(H);
        chk("single_size", 32'(cap.size()), 32'(H));
        chk("single_first", 32'(cap[0]), 32'h0);
        chk("single_mid", 32'(cap[300]), 32'd300);
        chk("single_last", 32'(cap[639]), 32'd639);
        chk("single_nouf", 32'(uf_seen), 32'd0);

        // Request with no line buffered
        clear_cap();
        req_burst(H);
        chk_all_uc("empty");
        chk("empty_uf_pulses", 32'(uf_seen), 32'd1);
`ifdef VGA_LB_UNDERFLOW_CNT_EN
        chk("empty_ucnt", 32'(underflow_cnt), 32'd1);
`endif

        // Backpressure
        flush();
        for (int i = 0; i < 2 * H; i++) push_px(16'h4000 + 16'(i), (i % H) == 0);
        write_end();
        chk("bp_ready_low", 32'(wr_ready), 32'd0);
        clear_cap();
        req_burst(H);
        chk("bp_ready_high", 32'(wr_ready), 32'd1);
        chk("bp_first", 32'(cap[0]), 32'h4000);
        clear_cap();
        req_burst(H);
        chk("bp_second", 32'(cap[0]), 32'h4280);

        // Resync mid-line
        flush();
        for (int i = 0; i < 100; i++) push_px(16'h1000 + 16'(i), i == 0);
        push_px(16'hAAAA, 1'b1);
        for (int i = 1; i < H; i++) push_px(16'h2000 + 16'(i), 1'b0);
        write_end();
        clear_cap();
        req_burst(H);
        chk("resync_first", 32'(cap[0]), 32'hAAAA);
        chk("resync_second", 32'(cap[1]), 32'h2001);
        begin
            int stale;
            stale = 0;
            foreach (cap[k]) if (cap[k] >= 16'h1000 && cap[k] < 16'h1064) stale++;
            chk("resync_stale", 32'(stale), 32'd0);
        end

        // Flush in the middle of a read
        flush();
        for (int i = 0; i < H; i++) push_px(16'h3000 + 16'(i), i == 0);
        write_end();
        clear_cap();
        for (int i = 0; i < 300; i++) begin
            data_req = 1'b1;
            @(negedge clk);
        end
        data_req    = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        data_req    = 1'b0;
        frame_start = 1'b0;
        chk("flush_rd_zero", 32'(rd_data), 32'd0);
        chk("flush_ready", 32'(wr_ready), 32'd1);
        chk("flush_pre", 32'(cap[299]), 32'h312B);
        @(negedge clk);
        clear_cap();
        req_burst(H);
        chk_all_uc("flush_after");
        chk("flush_uf_pulses", 32'(uf_seen), 32'd1);

        // Reset mid-line drops the partial line
        for (int i = 0; i < 300; i++) push_px(16'h5000 + 16'(i), i == 0);
        write_end();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_cap();
        req_burst(H);
        chk_all_uc("rst_mid");

        // Steady state: 1 px/cycle upstream, 800-cycle display lines
        flush();
        clear_cap();
        fork
            begin
                for (int l = 0; l < 5; l++)
                    for (int i = 0; i < H; i++)
                        push_px(16'((l << 12) | i), i == 0);
                write_end();
            end
            begin
                repeat (700) @(negedge clk);
                for (int l = 0; l < 4; l++) begin
                    for (int i = 0; i < H; i++) begin
                        data_req = 1'b1;
                        @(negedge clk);
                    end
                    data_req = 1'b0;
                    repeat (160) @(negedge clk);
                end
            end
        join
        chk("steady_uf", 32'(uf_seen), 32'd0);
        chk("steady_size", 32'(cap.size()), 32'(4 * H));
        chk("steady_l0", 32'(cap[0]), 32'h0000);
        chk("steady_l1", 32'(cap[640]), 32'h1000);
        chk("steady_l3_last", 32'(cap[2559]), 32'h327F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
